// File: rtl/demux16_skid.sv
// demux16_skid: 1-to-16 routing stage with a two-entry skid buffer.
// One word plus a 4-bit destination index enters on a valid/ready channel
// and leaves on exactly one of 16 valid/ready output channels.
// Optional build macro DEMUX16_CNT_EN adds per-channel drain counters
// (xfer_cnt) with a synchronous clear (cnt_clr).
//
// Handshake rules (all channels): a transfer happens on a rising clk edge
// where valid and ready are both 1; the sender holds valid/payload until
// then. in_ready is a pure register and never depends on out_ready in the
// same cycle. Only the head entry's channel can see valid, and the head
// entry drains when out_ready of that channel is 1.
module demux16_skid #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_sel,
  input  logic [WIDTH-1:0]  in_data,
  output logic [15:0]       out_valid,
  input  logic [15:0]       out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy
`ifdef DEMUX16_CNT_EN
  ,
  input  logic              cnt_clr,
  output logic [127:0]      xfer_cnt
`endif
);

  // State encoding doubles as the entry count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic [3:0]       r_head_sel;
  logic [WIDTH-1:0] r_head_data;
  logic [3:0]       r_tail_sel;
  logic [WIDTH-1:0] r_tail_data;

  logic             w_accept;
  logic             w_drain;
  logic [1:0]       w_next_state;
  logic             w_head_from_in;
  logic             w_tail_from_in;
  logic             w_head_from_tail;
  logic [15:0]      w_out_valid;

  assign w_accept = in_valid & r_in_ready;
  assign w_drain  = (r_state != ST_EMPTY) & out_ready[r_head_sel];

  // Next-state and entry-load decisions for the skid FIFO.
  always_comb begin
    w_next_state     = r_state;
    w_head_from_in   = 1'b0;
    w_tail_from_in   = 1'b0;
    w_head_from_tail = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_next_state   = ST_ONE;
          w_head_from_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_drain) begin
          w_next_state   = ST_ONE;
          w_head_from_in = 1'b1;
        end else if (w_accept) begin
          w_next_state   = ST_TWO;
          w_tail_from_in = 1'b1;
        end else if (w_drain) begin
          w_next_state   = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is 0 here, so only a drain can happen.
        if (w_drain) begin
          w_next_state     = ST_ONE;
          w_head_from_tail = 1'b1;
        end
      end
      default: begin
        w_next_state = ST_EMPTY;
      end
    endcase
  end

  // State and registered in_ready; in_ready drops only when the buffer fills.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != ST_TWO);
    end
  end

  // Head entry: loaded from the input or promoted from the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head_sel  <= 4'd0;
      r_head_data <= '0;
    end else if (w_head_from_in) begin
      r_head_sel  <= in_sel;
      r_head_data <= in_data;
    end else if (w_head_from_tail) begin
      r_head_sel  <= r_tail_sel;
      r_head_data <= r_tail_data;
    end
  end

  // Tail entry: the skid slot, written only when the head is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tail_sel  <= 4'd0;
      r_tail_data <= '0;
    end else if (w_tail_from_in) begin
      r_tail_sel  <= in_sel;
      r_tail_data <= in_data;
    end
  end

  // One-hot valid decode of the head's destination.
  always_comb begin
    w_out_valid = 16'd0;
    if (r_state != ST_EMPTY) begin
      w_out_valid[r_head_sel] = 1'b1;
    end
  end

  assign out_valid = w_out_valid;
  assign out_data  = r_head_data;
  assign in_ready  = r_in_ready;
  assign occupancy = r_state;

`ifdef DEMUX16_CNT_EN
  logic [7:0] r_cnt [16];

  // Per-channel drain counters; clear wins over a coincident drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 16; k++) r_cnt[k] <= 8'd0;
    end else if (cnt_clr) begin
      for (int k = 0; k < 16; k++) r_cnt[k] <= 8'd0;
    end else if (w_drain) begin
      r_cnt[r_head_sel] <= r_cnt[r_head_sel] + 8'd1;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_cnt_flat
    assign xfer_cnt[8*g +: 8] = r_cnt[g];
  end
`endif

endmodule

// File: tb/tb_demux16_skid.sv
// tb_demux16_skid: self-checking bench for demux16_skid.
// Table-driven streaming vectors plus hand sequences for stall, blocking,
// accept-with-drain and reset corner cases. Define DEMUX16_CNT_EN to also
// exercise the drain counters.
module tb_demux16_skid;

  localparam int WIDTH = 32;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        in_sel;
  logic [WIDTH-1:0]  in_data;
  logic [15:0]       out_valid;
  logic [15:0]       out_ready;
  logic [WIDTH-1:0]  out_data;
  logic [1:0]        occupancy;
`ifdef DEMUX16_CNT_EN
  logic              cnt_clr;
  logic [127:0]      xfer_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // {expected one-hot valid, expected data}
  logic [16+WIDTH-1:0] exp_q[$];

  typedef struct {
    logic [3:0]       sel;
    logic [WIDTH-1:0] data;
    logic [15:0]      exp_valid;
  } vec_t;

  vec_t tbl[20];

  demux16_skid #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
`ifdef DEMUX16_CNT_EN
    ,
    .cnt_clr   (cnt_clr),
    .xfer_cnt  (xfer_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one word and hold it until the block accepts it (bounded).
  task automatic send(input logic [3:0] sel, input logic [WIDTH-1:0] data);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      exp_q.push_back({16'd1 << sel, data});
      @(posedge clk); #1;
    end else begin
      chk("send_timeout", 1, 0);
      in_valid = 1'b0;
    end
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sel   = $urandom_range(0, 15);
    in_data  = $urandom;
  endtask

  // Scoreboard: whenever a word is visible it must match the queue head;
  // it is retired when its channel is ready.
  always @(negedge clk) begin
    if (rst_n && out_valid != 16'd0) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", out_valid, 0);
      end else begin
        chk("sb_valid", out_valid, exp_q[0][16+WIDTH-1:WIDTH]);
        chk("sb_data", out_data, exp_q[0][WIDTH-1:0]);
        if ((out_valid & out_ready) != 16'd0) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [WIDTH-1:0] d;
    rst_n     = 1'b0;
    out_ready = 16'd0;
`ifdef DEMUX16_CNT_EN
    cnt_clr   = 1'b0;
`endif
    idle();

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready_pre_edge", in_ready, 0);
    @(posedge clk); #1;
    chk("rel_in_ready_post_edge", in_ready, 1);

    // Streaming: back-to-back words, all sinks ready
    for (int i = 0; i < 20; i++) begin
      tbl[i].sel       = 4'(i % 16);
      tbl[i].data      = $urandom;
      tbl[i].exp_valid = 16'd1 << (i % 16);
    end
    out_ready = 16'hFFFF;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_sel   = tbl[i].sel;
      in_data  = tbl[i].data;
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1);
      if (i > 0) begin
        chk("stream_valid", out_valid, tbl[i-1].exp_valid);
        chk("stream_data", out_data, tbl[i-1].data);
      end
      exp_q.push_back({tbl[i].exp_valid, tbl[i].data});
      @(posedge clk); #1;
    end
    idle();
    @(negedge clk);
    chk("stream_last_valid", out_valid, tbl[19].exp_valid);
    chk("stream_last_data", out_data, tbl[19].data);
    @(posedge clk); #1;
    chk("stream_empty", occupancy, 0);

    // Fill and stall
    out_ready = 16'd0;
    send(4'd3, 32'hA5A5A5A5);
    send(4'd9, 32'h12345678);
    idle();
    @(negedge clk);
    chk("fill_occupancy", occupancy, 2);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_valid", out_valid, 16'h0008);
    chk("fill_data", out_data, 32'hA5A5A5A5);
    @(posedge clk); #1;
    out_ready = 16'h0008;
    @(posedge clk); #1;
    out_ready = 16'd0;
    @(negedge clk);
    chk("unstall_valid", out_valid, 16'h0200);
    chk("unstall_data", out_data, 32'h12345678);
    chk("unstall_in_ready", in_ready, 1);
    chk("unstall_occupancy", occupancy, 1);
    @(posedge clk); #1;
    out_ready = 16'hFFFF;
    @(posedge clk); #1;
    chk("unstall_empty", occupancy, 0);

    // Head-of-line blocking
    out_ready = 16'h0040;
    send(4'd5, 32'h55550005);
    send(4'd6, 32'h66660006);
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hol_blocked", out_valid, 16'h0020);
    end
    @(posedge clk); #1;
    out_ready = 16'h0060;
    @(posedge clk); #1;
    @(negedge clk);
    chk("hol_released_valid", out_valid, 16'h0040);
    chk("hol_released_data", out_data, 32'h66660006);
    @(posedge clk); #1;
    chk("hol_empty", occupancy, 0);

    // Simultaneous accept and drain in ONE
    out_ready = 16'd0;
    send(4'd1, 32'hAAAA0001);
    out_ready = 16'hFFFF;
    send(4'd2, 32'hBBBB0002);
    idle();
    @(negedge clk);
    chk("swap_occupancy", occupancy, 1);
    chk("swap_valid", out_valid, 16'h0004);
    chk("swap_data", out_data, 32'hBBBB0002);
    @(posedge clk); #1;

    // Reset mid-operation with two words held
    out_ready = 16'd0;
    send(4'd7, 32'h77777777);
    send(4'd8, 32'h88888888);
    idle();
    @(negedge clk);
    chk("midrst_pre_occupancy", occupancy, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_occupancy", occupancy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_data", out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 16'hFFFF;
    @(posedge clk); #1;
    chk("midrst_in_ready_after", in_ready, 1);
    @(negedge clk);
    chk("midrst_words_lost", out_valid, 0);
    @(posedge clk); #1;

`ifdef DEMUX16_CNT_EN
    // Counter wrap on channel 0
    for (int i = 0; i < 255; i++) send(4'd0, $urandom);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_ch0_255", xfer_cnt[7:0], 8'd255);
    send(4'd0, $urandom);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_ch0_wrap", xfer_cnt[7:0], 8'd0);
    for (int i = 0; i < 3; i++) send(4'd4, $urandom);
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("cnt_ch4_three", xfer_cnt[39:32], 8'd3);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_all", xfer_cnt, 0);
    // Clear coincident with a drain
    d = $urandom;
    send(4'd4, d);
    idle();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    chk("cnt_clr_with_drain", xfer_cnt, 0);
    @(posedge clk); #1;
`endif

    // Drain anything left, bounded
    for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
